// File: rtl/select_pkg.sv
// Shared types and constants for the selection-round controller.
// Holds the FSM state encoding, result width, NONE code and key count.
package select_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int                SEL_W    = 3;
    localparam logic [SEL_W-1:0]  SEL_NONE = 3'd7;
    localparam int                KEY_N    = 4;

    // Lowest set bit wins; NONE when no bit is set.
    function automatic logic [SEL_W-1:0] lowest_key(input logic [KEY_N-1:0] edges);
        logic [SEL_W-1:0] idx;
        idx = SEL_NONE;
        for (int i = KEY_N - 1; i >= 0; i--) begin
            if (edges[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/select_tick_div.sv
// One-second tick divider: one-cycle tick every TICK_DIV enabled cycles.
// Latency: tick is combinational from the count register; clr is synchronous. No backpressure.
module select_tick_div #(
    parameter int TICK_DIV = 2
) (
    input  logic clk_2,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [7:0] cnt_q, cnt_d;

    assign tick = en & ~clr & (cnt_q == 8'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/select_round_ctrl.sv
// Selection-round controller: start edge opens a timed round, first key edge latches the winner.
// Latency 1 cycle from sampled edge to registered outputs; no backpressure. Option: SELECT_TIMEOUT_EN.
module select_round_ctrl
    import select_pkg::*;
#(
    parameter int TICK_DIV  = 2,
    parameter int ROUND_SEC = 9
) (
    input  logic             clk_2,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_N-1:0] key,
    output logic             finnal_flag,
    output logic [SEL_W-1:0] sel_id,
    output logic [3:0]       time_left,
    output logic             busy
);

    state_t           state_q, state_d;
    logic             start_q, arm_q;
    logic [KEY_N-1:0] key_q;
    logic             flag_q, flag_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [3:0]       tl_q, tl_d;
    logic             busy_q, busy_d;

    logic             start_rise;
    logic [KEY_N-1:0] key_rise;
    logic             tick;

    // arm_q blocks a start held high straight out of reset from counting as an edge.
    assign start_rise = start & ~start_q & arm_q;
    assign key_rise   = key & ~key_q;

    select_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
        .clk_2 (clk_2),
        .rst_n (rst_n),
        .clr   (start_rise),
        .en    (state_q == RUN),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        flag_d  = flag_q;
        sel_d   = sel_q;
        tl_d    = tl_q;
        busy_d  = busy_q;
        if (start_rise) begin
            state_d = RUN;
            flag_d  = 1'b1;
            sel_d   = SEL_NONE;
            tl_d    = 4'(ROUND_SEC);
            busy_d  = 1'b1;
        end else if (state_q == RUN) begin
            if (|key_rise) begin
                state_d = DONE;
                flag_d  = 1'b0;
                sel_d   = lowest_key(key_rise);
                busy_d  = 1'b0;
`ifdef SELECT_TIMEOUT_EN
            end else if (tl_q == 4'd0) begin
                state_d = DONE;
                flag_d  = 1'b0;
                sel_d   = SEL_NONE;
                busy_d  = 1'b0;
`endif
            end else if (tick && tl_q != 4'd0) begin
                tl_d = tl_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            arm_q   <= 1'b0;
            key_q   <= '0;
            flag_q  <= 1'b1;
            sel_q   <= SEL_NONE;
            tl_q    <= 4'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            arm_q   <= arm_q | ~start;
            key_q   <= key;
            flag_q  <= flag_d;
            sel_q   <= sel_d;
            tl_q    <= tl_d;
            busy_q  <= busy_d;
        end
    end

    assign finnal_flag = flag_q;
    assign sel_id      = sel_q;
    assign time_left   = tl_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_select_round_ctrl.sv
// Bench for select_round_ctrl: directed scenarios plus random traffic against a round-level model.
module tb_select_round_ctrl;

    localparam int TD = 2;
    localparam int RS = 3;

    logic       clk_2 = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] key;
    logic       finnal_flag;
    logic [2:0] sel_id;
    logic [3:0] time_left;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    select_round_ctrl #(.TICK_DIV(TD), .ROUND_SEC(RS)) dut (
        .clk_2       (clk_2),
        .rst_n       (rst_n),
        .start       (start),
        .key         (key),
        .finnal_flag (finnal_flag),
        .sel_id      (sel_id),
        .time_left   (time_left),
        .busy        (busy)
    );

    always #5 clk_2 = ~clk_2;

    // Round-level model: phase 0 idle, 1 running, 2 decided.
    int       m_phase, m_cyc, m_tl, m_sel;
    bit       m_flag, m_busy, m_armed, m_pstart;
    bit [3:0] m_pkey;

    always @(posedge clk_2 or negedge rst_n) begin
        bit [3:0] ke;
        int       win;
        if (!rst_n) begin
            m_phase = 0; m_cyc = 0; m_tl = 0; m_sel = 7;
            m_flag = 1; m_busy = 0; m_armed = 0; m_pstart = 0; m_pkey = 0;
        end else begin
            ke  = key & ~m_pkey;
            win = -1;
            for (int i = 3; i >= 0; i--) if (ke[i]) win = i;
            if (start && !m_pstart && m_armed) begin
                m_phase = 1; m_cyc = 0; m_tl = RS; m_sel = 7; m_flag = 1; m_busy = 1;
            end else if (m_phase == 1) begin
                if (win >= 0) begin
                    m_phase = 2; m_sel = win; m_flag = 0; m_busy = 0;
`ifdef SELECT_TIMEOUT_EN
                end else if (m_tl == 0) begin
                    m_phase = 2; m_sel = 7; m_flag = 0; m_busy = 0;
`endif
                end else begin
                    m_cyc++;
                    m_tl = RS - m_cyc / TD;
                    if (m_tl < 0) m_tl = 0;
                end
            end
            if (!start) m_armed = 1;
            m_pstart = start;
            m_pkey   = key;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_2) begin
        if (cmp_en) begin
            chk("model_flag", 32'(finnal_flag), 32'(m_flag));
            chk("model_sel",  32'(sel_id),      32'(m_sel));
            chk("model_tl",   32'(time_left),   32'(m_tl));
            chk("model_busy", 32'(busy),        32'(m_busy));
        end
    end

    // Inputs change 3 time units after the rising edge; results are read at the same offset.
    task automatic step(input logic s, input logic [3:0] k);
        start = s;
        key   = k;
        @(posedge clk_2);
        #3;
    endtask

    task automatic chk_out(input string nm, input int f, input int s, input int t, input int b);
        chk({nm, "_flag"}, 32'(finnal_flag), 32'(f));
        chk({nm, "_sel"},  32'(sel_id),      32'(s));
        chk({nm, "_tl"},   32'(time_left),   32'(t));
        chk({nm, "_busy"}, 32'(busy),        32'(b));
    endtask

    int exp_tl [6] = '{3, 2, 2, 1, 1, 0};

    initial begin
        rst_n = 1'b0; start = 1'b1; key = 4'b0001;
        @(posedge clk_2); #3;
        cmp_en = 1'b1;
        repeat (2) step(1, 4'b0001);
        chk_out("reset", 1, 7, 0, 0);
        rst_n = 1'b1;

        // Start held high across reset is not an edge until it has been seen low.
        repeat (3) step(1, 4'b0001);
        chk("start_held_busy", 32'(busy), 32'd0);
        step(0, 4'b0001);
        step(1, 4'b0001);
        chk_out("start_edge", 1, 7, RS, 1);

        // Key 0 held from before the round does not select; re-press does.
        step(0, 4'b0001);
        step(0, 4'b0001);
        chk("held_key_busy", 32'(busy), 32'd1);
        step(0, 4'b0000);
        step(0, 4'b0001);
        chk("repress_sel", 32'(sel_id), 32'd0);
        chk("repress_flag", 32'(finnal_flag), 32'd0);

        // Key 2 rises three cycles after the start edge; the result then holds.
        step(1, 4'b0000);
        step(0, 4'b0000);
        step(0, 4'b0000);
        step(0, 4'b0100);
        chk_out("key2", 0, 2, 2, 0);
        for (int i = 0; i < 50; i++) begin
            step(0, 4'($urandom));
            chk("done_hold_flag", 32'(finnal_flag), 32'd0);
            chk("done_hold_sel",  32'(sel_id),      32'd2);
        end

        // Restart from DONE.
        step(1, 4'b0000);
        chk_out("restart", 1, 7, RS, 1);

        // Simultaneous key 1 and key 3 edges.
        step(0, 4'b0000);
        step(0, 4'b1010);
        chk("multi_key_sel", 32'(sel_id), 32'd1);

        // Time-out behaviour with no keys.
        step(0, 4'b0000);
        step(1, 4'b0000);
        chk("tl_start", 32'(time_left), 32'd3);
        for (int i = 0; i < 6; i++) begin
            step(0, 4'b0000);
            chk("tl_seq", 32'(time_left), 32'(exp_tl[i]));
        end
        step(0, 4'b0000);
`ifdef SELECT_TIMEOUT_EN
        chk_out("timeout", 0, 7, 0, 0);
`else
        for (int i = 0; i < 100; i++) begin
            chk_out("no_timeout", 1, 7, 0, 1);
            step(0, 4'b0000);
        end
`endif

        // Reset mid-round at time_left 2, then a fresh start.
        step(1, 4'b0000);
        step(0, 4'b0000);
        step(0, 4'b0000);
        chk("pre_reset_tl", 32'(time_left), 32'd2);
        rst_n = 1'b0;
        #1;
        chk_out("mid_reset", 1, 7, 0, 0);
        #1;
        step(0, 4'b0000);
        rst_n = 1'b1;
        step(0, 4'b0000);
        chk_out("post_reset", 1, 7, 0, 0);
        step(1, 4'b0000);
        chk_out("reload", 1, 7, RS, 1);

        // Random traffic: sparse start pulses, flickering keys, occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic       s;
            logic [3:0] k;
            s = ($urandom_range(0, 15) == 0);
            k = key;
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) k[b] = ~k[b];
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                step(s, k);
                rst_n = 1'b1;
            end else begin
                step(s, k);
            end
        end

        @(negedge clk_2);
        #1;
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
